// File: rtl/fsm3_onehot_seq.sv
// fsm3_onehot_seq: four-state one-hot Moore sequencer (A, B, C, D) with
// input-valid gating, a D-entry pulse, a saturating D-entry counter,
// sticky illegal-state detection with one-cycle recovery to A, and a raw
// state-load hook used to force arbitrary (even non-one-hot) values.
module fsm3_onehot_seq #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid_i,
  input  logic             in_i,
  input  logic             inj_en_i,
  input  logic [3:0]       inj_state_i,
  input  logic             cnt_clr_i,
  output logic [3:0]       state_o,
  output logic             out_o,
  output logic             out_pulse_o,
  output logic [CNT_W-1:0] hit_count_o,
  output logic             err_o
);

  typedef enum logic [3:0] {
    ST_A = 4'b0001,
    ST_B = 4'b0010,
    ST_C = 4'b0100,
    ST_D = 4'b1000
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // A state is legal only when exactly one bit is set.
  function automatic logic is_onehot(input logic [3:0] v);
    logic [2:0] ones;
    ones = 3'd0;
    for (int i = 0; i < 4; i++) begin
      ones = ones + {2'b00, v[i]};
    end
    return (ones == 3'd1);
  endfunction

  logic [3:0]       state_q, state_d;
  logic [3:0]       table_next_s;
  logic             pulse_q, pulse_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // Transition table lookup, used only when the state is legal and in is valid.
  always_comb begin
    table_next_s = ST_A;
    case (state_q)
      ST_A:    table_next_s = in_i ? ST_B : ST_A;
      ST_B:    table_next_s = in_i ? ST_B : ST_C;
      ST_C:    table_next_s = in_i ? ST_D : ST_A;
      ST_D:    table_next_s = in_i ? ST_B : ST_C;
      default: table_next_s = ST_A;
    endcase
  end

  // Prioritised next-state, pulse, counter and error update.
  always_comb begin
    state_d = state_q;
    pulse_d = 1'b0;
    err_d   = err_q;
    if (inj_en_i) begin
      // Raw load: no counting, no pulse, error flag untouched.
      state_d = inj_state_i;
    end else if (!is_onehot(state_q)) begin
      // Recover to A in one cycle; in_valid/in are ignored here.
      state_d = ST_A;
      err_d   = 1'b1;
    end else if (in_valid_i) begin
      state_d = table_next_s;
      pulse_d = (table_next_s == ST_D);
    end else begin
      state_d = state_q;
    end

    cnt_d = cnt_q;
    if (cnt_clr_i) begin
      // Clear wins over a coincident increment; the pulse still fires.
      cnt_d = {CNT_W{1'b0}};
    end else if (pulse_d && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State, pulse, counter and sticky error registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_A;
      pulse_q <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign state_o     = state_q;
  assign out_o       = state_q[3];
  assign out_pulse_o = pulse_q;
  assign hit_count_o = cnt_q;
  assign err_o       = err_q;

endmodule
